// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier feeder: FSM encoding,
// default operand width and the watchdog limit formula.
package booth_pkg;

  localparam int unsigned N_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    LOADM   = 3'd2,
    LOADQ   = 3'd3,
    WAIT    = 3'd4,
    CAPTURE = 3'd5,
    FLUSH   = 3'd6
  } state_t;

  // Cycles allowed from start to done before the core is declared hung.
  function automatic int unsigned tmo_cycles(input int unsigned n);
    return 2 * n + 8;
  endfunction

endpackage

// File: rtl/booth_op_fifo.sv
// Synchronous operand-pair FIFO with extra-MSB pointers; read data is the
// current head, taken straight from storage.
module booth_op_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; only the pointers define occupancy.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/booth_op_sequencer.sv
// Feeder for the Booth multiplier core: queues operand pairs, sequences the
// core's shared operand bus, captures the product and holds it for the consumer.
module booth_op_sequencer
  import booth_pkg::*;
#(
  parameter int unsigned N     = N_DEFAULT,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TMO   = tmo_cycles(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           op_valid,
  output logic           op_ready,
  input  logic [N-1:0]   op_m,
  input  logic [N-1:0]   op_q,
  output logic           mul_start,
  output logic [N-1:0]   mul_data,
  output logic           mul_rst,
  input  logic           mul_done,
  input  logic [2*N-1:0] mul_prod,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*N-1:0] res_prod,
  output logic           res_err
);

  localparam int unsigned WDW = $clog2(TMO + 1);

  state_t           state_q, state_d;
  logic [N-1:0]     m_q, m_d;
  logic [N-1:0]     q_q, q_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic             res_valid_q, res_valid_d;
  logic [2*N-1:0]   res_prod_q, res_prod_d;
  logic             res_err_q, res_err_d;
  logic             mul_start_q, mul_start_d;
  logic [N-1:0]     mul_data_q, mul_data_d;
  logic             mul_rst_q, mul_rst_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic [2*N-1:0]   fifo_rdata;
  logic             fifo_push;
  logic             fifo_pop;

  assign fifo_push = op_valid && !fifo_full;
  assign fifo_pop  = (state_q == ISSUE);
  assign op_ready  = !fifo_full;

  booth_op_fifo #(
    .W     (2 * N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({op_m, op_q}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next state, operand latch, watchdog and result register.
  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    q_d         = q_q;
    wd_d        = wd_q;
    res_valid_d = res_valid_q;
    res_prod_d  = res_prod_q;
    res_err_d   = res_err_q;

    if (res_valid_q && res_ready) res_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty && !res_valid_q) begin
          state_d = ISSUE;
          m_d     = fifo_rdata[2*N-1:N];
          q_d     = fifo_rdata[N-1:0];
        end
      end
      ISSUE: state_d = LOADM;
      LOADM: state_d = LOADQ;
      LOADQ: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (wd_q != {WDW{1'b1}}) wd_d = wd_q + WDW'(1);
        // Result is written on the edge into CAPTURE so it is visible there.
        if (mul_done) begin
          state_d     = CAPTURE;
          res_valid_d = 1'b1;
          res_prod_d  = mul_prod;
          res_err_d   = 1'b0;
        end else if (wd_q == WDW'(TMO)) begin
          state_d     = CAPTURE;
          res_valid_d = 1'b1;
          res_prod_d  = '0;
          res_err_d   = 1'b1;
        end
      end
      CAPTURE: state_d = FLUSH;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Core-facing outputs are registered from the state being entered.
    mul_start_d = (state_d == ISSUE);
    mul_rst_d   = (state_d == FLUSH);
    case (state_d)
      ISSUE, LOADM: mul_data_d = m_d;
      LOADQ, WAIT:  mul_data_d = q_d;
      default:      mul_data_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      m_q         <= '0;
      q_q         <= '0;
      wd_q        <= '0;
      res_valid_q <= 1'b0;
      res_prod_q  <= '0;
      res_err_q   <= 1'b0;
      mul_start_q <= 1'b0;
      mul_data_q  <= '0;
      mul_rst_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      q_q         <= q_d;
      wd_q        <= wd_d;
      res_valid_q <= res_valid_d;
      res_prod_q  <= res_prod_d;
      res_err_q   <= res_err_d;
      mul_start_q <= mul_start_d;
      mul_data_q  <= mul_data_d;
      mul_rst_q   <= mul_rst_d;
    end
  end

  assign mul_start = mul_start_q;
  assign mul_data  = mul_data_q;
  assign mul_rst   = mul_rst_q;
  assign res_valid = res_valid_q;
  assign res_prod  = res_prod_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_booth_op_sequencer.sv
// Bench for booth_op_sequencer: a timestamp-based model of the issue/result
// schedule, a behavioural Booth core stand-in and directed operand vectors.
module tb_booth_op_sequencer;

  localparam int N     = 16;
  localparam int DEPTH = 4;
  localparam int TMO   = 40;
  localparam int LAT   = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [15:0] op_m = '0;
  logic [15:0] op_q = '0;
  logic        mul_done = 1'b0;
  logic [31:0] mul_prod = '0;
  logic        res_ready = 1'b0;
  logic        op_ready;
  logic        mul_start;
  logic [15:0] mul_data;
  logic        mul_rst;
  logic        res_valid;
  logic [31:0] res_prod;
  logic        res_err;

  booth_op_sequencer #(.N(16), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_m      (op_m),
    .op_q      (op_q),
    .mul_start (mul_start),
    .mul_data  (mul_data),
    .mul_rst   (mul_rst),
    .mul_done  (mul_done),
    .mul_prod  (mul_prod),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_prod  (res_prod),
    .res_err   (res_err)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Core stand-in: loads M then Q, raises done LAT cycles into WAIT.
  bit          hang = 1'b0;
  int          core_phase = 0;
  int          core_s = 0;
  logic [15:0] core_m = '0;
  logic [15:0] core_q = '0;
  int          ca, cb;
  initial forever begin
    @(posedge clk); #1;
    if (mul_rst === 1'b1) begin
      core_phase = 0; mul_done = 1'b0; mul_prod = '0;
    end else if (mul_start === 1'b1) begin
      core_phase = 1; core_s = cyc;
    end else if (core_phase == 1) begin
      core_m = mul_data; core_phase = 2;
    end else if (core_phase == 2) begin
      core_q = mul_data; core_phase = 3;
    end else if (core_phase == 3 && !hang && cyc == core_s + 3 + LAT) begin
      ca = int'($signed(core_m));
      cb = int'($signed(core_q));
      mul_done = 1'b1;
      mul_prod = 32'(ca * cb);
    end
  end

  // Observation logs for the directed literal checks.
  int          st_log[$];
  int          rv_log[$];
  logic [31:0] res_log_p[$];
  logic        res_log_e[$];
  bit          prev_rv = 1'b0;
  always @(negedge clk) begin
    if (mul_start === 1'b1) st_log.push_back(cyc);
    if (res_valid === 1'b1 && !prev_rv) rv_log.push_back(cyc);
    if (res_valid === 1'b1 && res_ready) begin
      res_log_p.push_back(res_prod);
      res_log_e.push_back(res_err);
    end
    prev_rv = (res_valid === 1'b1);
  end

  // Schedule model: operands queue, an op occupies [start, capture+1],
  // issue follows one cycle after an idle cycle with work and no held result.
  logic [15:0] mq_m[$];
  logic [15:0] mq_q[$];
  bit          model_on = 1'b0;
  bit          active = 1'b0;
  bit          cur_hang = 1'b0;
  int          t_start = 0;
  int          t_cap = 0;
  int          rst_cyc = -10;
  logic [15:0] cur_m = '0;
  logic [15:0] cur_q = '0;
  bit          exp_rv = 1'b0;
  logic [31:0] exp_prod = '0;
  bit          exp_err = 1'b0;
  int          c, pa;
  bit          e_ready, e_start, e_mrst, nonempty, idle_now, rv_now;
  logic [15:0] e_data;

  always @(negedge clk) begin
    c       = cyc;
    e_ready = (mq_m.size() < DEPTH);
    e_start = active && (c == t_start);
    if (active && (c == t_start || c == t_start + 1))   e_data = cur_m;
    else if (active && c >= t_start + 2 && c < t_cap)   e_data = cur_q;
    else                                                e_data = '0;
    e_mrst = (active && c == t_cap + 1) || (c == rst_cyc);
    if (model_on) begin
      chk("op_ready",  64'(op_ready),  64'(e_ready));
      chk("mul_start", 64'(mul_start), 64'(e_start));
      chk("mul_data",  64'(mul_data),  64'(e_data));
      chk("mul_rst",   64'(mul_rst),   64'(e_mrst));
      chk("res_valid", 64'(res_valid), 64'(exp_rv));
      chk("res_prod",  64'(res_prod),  64'(exp_prod));
      chk("res_err",   64'(res_err),   64'(exp_err));
    end
    if (rst) begin
      model_on = 1'b1;
      active   = 1'b0;
      mq_m.delete();
      mq_q.delete();
      exp_rv   = 1'b0;
      exp_prod = '0;
      exp_err  = 1'b0;
      rst_cyc  = c + 1;
    end else if (model_on) begin
      nonempty = (mq_m.size() > 0);
      idle_now = !(active && c < t_cap + 2);
      rv_now   = exp_rv;
      if (active && c == t_start) begin
        void'(mq_m.pop_front());
        void'(mq_q.pop_front());
      end
      if (op_valid && e_ready) begin
        mq_m.push_back(op_m);
        mq_q.push_back(op_q);
      end
      if (exp_rv && res_ready) exp_rv = 1'b0;
      if (active && c + 1 == t_cap) begin
        pa       = int'($signed(cur_m)) * int'($signed(cur_q));
        exp_rv   = 1'b1;
        exp_prod = cur_hang ? 32'h0 : 32'(pa);
        exp_err  = cur_hang;
      end
      if (idle_now && nonempty && !rv_now) begin
        cur_m    = mq_m[0];
        cur_q    = mq_q[0];
        cur_hang = hang;
        t_start  = c + 1;
        t_cap    = t_start + 4 + (hang ? TMO : LAT);
        active   = 1'b1;
      end
    end
  end

  task automatic push_op(input logic [15:0] m, input logic [15:0] q);
    bit ok;
    ok = 1'b0;
    op_valid = 1'b1; op_m = m; op_q = q;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (op_ready) begin ok = 1'b1; break; end
    end
    chk("push_accept", 64'(ok), 64'(1'b1));
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic wait_log(input int n, input int lim);
    for (int k = 0; k < lim; k++) begin
      if (res_log_p.size() >= n) break;
      @(posedge clk); #1;
    end
    chk("wait_result", 64'(res_log_p.size()), 64'(n));
  endtask

  task automatic wait_rv(input int n, input int lim);
    for (int k = 0; k < lim; k++) begin
      if (rv_log.size() >= n) break;
      @(posedge clk); #1;
    end
    chk("wait_valid", 64'(rv_log.size()), 64'(n));
  endtask

  task automatic wait_st(input int n, input int lim);
    for (int k = 0; k < lim; k++) begin
      if (st_log.size() >= n) break;
      @(posedge clk); #1;
    end
    chk("wait_start", 64'(st_log.size()), 64'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, at cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

  int n0, h, rs;

  initial begin
    rst = 1'b1; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single op 3 x -4.
    push_op(16'h0003, 16'hFFFC);
    wait_log(1, 100);
    chk("t1_prod",    64'(res_log_p[0]), 64'(32'hFFFF_FFF4));
    chk("t1_err",     64'(res_log_e[0]), 64'(1'b0));
    chk("t1_latency", 64'(rv_log[0] - st_log[0]), 64'(24));
    chk("t1_core_m",  64'(core_m), 64'(16'h0003));
    chk("t1_core_q",  64'(core_q), 64'(16'hFFFC));

    // Five ops; FIFO fills with four while the first is in the core.
    push_op(16'h8000, 16'h8000);
    repeat (4) @(posedge clk);
    #1;
    push_op(16'h7FFF, 16'h7FFF);
    push_op(16'h7FFF, 16'h8000);
    push_op(16'h8000, 16'h7FFF);
    push_op(16'h1234, 16'hFFFF);
    chk("t2_full", 64'(op_ready), 64'(1'b0));
    wait_log(6, 400);
    chk("t2_p1", 64'(res_log_p[1]), 64'(32'h4000_0000));
    chk("t2_p2", 64'(res_log_p[2]), 64'(32'h3FFF_0001));
    chk("t2_p3", 64'(res_log_p[3]), 64'(32'hC000_8000));
    chk("t2_p4", 64'(res_log_p[4]), 64'(32'hC000_8000));
    chk("t2_p5", 64'(res_log_p[5]), 64'(32'hFFFF_EDCC));

    // Held result blocks the second issue until the consumer takes it.
    res_ready = 1'b0;
    n0 = st_log.size();
    push_op(16'h0005, 16'h0006);
    push_op(16'hFFF9, 16'h0008);
    wait_rv(7, 100);
    repeat (20) @(posedge clk);
    #1;
    chk("t3_hold", 64'(st_log.size()), 64'(n0 + 1));
    res_ready = 1'b1; h = cyc;
    @(posedge clk); #1;
    res_ready = 1'b0;
    wait_st(n0 + 2, 10);
    chk("t3_restart", 64'(st_log[n0 + 1] - h), 64'(2));
    res_ready = 1'b1;
    wait_log(8, 100);
    chk("t3_p1", 64'(res_log_p[6]), 64'(32'h0000_001E));
    chk("t3_p2", 64'(res_log_p[7]), 64'(32'hFFFF_FFC8));

    // Core that never finishes, then a normal op.
    hang = 1'b1;
    push_op(16'h0009, 16'h0009);
    wait_log(9, 150);
    chk("t4_prod", 64'(res_log_p[8]), 64'(32'h0));
    chk("t4_err",  64'(res_log_e[8]), 64'(1'b1));
    chk("t4_tmo",  64'(rv_log[rv_log.size() - 1] - (st_log[st_log.size() - 1] + 2)), 64'(42));
    hang = 1'b0;
    push_op(16'hFFFE, 16'hFFFD);
    wait_log(10, 100);
    chk("t4_next_prod", 64'(res_log_p[9]), 64'(32'h0000_0006));
    chk("t4_next_err",  64'(res_log_e[9]), 64'(1'b0));

    // Reset while the core is in WAIT.
    n0 = st_log.size();
    push_op(16'd100, 16'd200);
    wait_st(n0 + 1, 20);
    rs = st_log[n0];
    for (int k = 0; k < 20; k++) begin
      if (cyc >= rs + 6) break;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_op_ready",  64'(op_ready),  64'(1'b1));
    chk("t5_mul_start", 64'(mul_start), 64'(1'b0));
    chk("t5_mul_data",  64'(mul_data),  64'(16'h0));
    chk("t5_mul_rst",   64'(mul_rst),   64'(1'b1));
    chk("t5_res_valid", 64'(res_valid), 64'(1'b0));
    chk("t5_res_prod",  64'(res_prod),  64'(32'h0));
    chk("t5_res_err",   64'(res_err),   64'(1'b0));
    push_op(16'hFF9C, 16'h0007);
    wait_log(11, 100);
    chk("t5_prod", 64'(res_log_p[10]), 64'(32'hFFFF_FD44));
    chk("t5_err",  64'(res_log_e[10]), 64'(1'b0));
    repeat (5) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
